// File: rtl/router_fifo.sv
// router_fifo: per-output-port packet FIFO for a byte router.
// Each entry holds {header flag, payload byte}. A packet byte counter follows
// reads so data_out is forced to zero once a packet has fully drained.
module router_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [6:0]       count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;

    // Storage is never cleared: once the pointers are equal nothing is reachable
    logic [WIDTH:0]   mem_q [DEPTH];

    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [WIDTH:0]   rd_word;
    logic [6:0]       hdr_count;
    logic             wr_acc;
    logic             rd_acc;

    assign wr_idx  = wr_ptr_q[AW-1:0];
    assign rd_idx  = rd_ptr_q[AW-1:0];
    assign rd_word = mem_q[rd_idx];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Accept decisions use the flags as they stand at the start of the cycle
    assign wr_acc = write_enb && !full;
    assign rd_acc = read_enb && !empty;

    // Header byte carries payload length in its upper bits; +1 covers the parity byte
    assign hdr_count = 7'(rd_word[WIDTH-1:2]) + 7'd1;

    assign data_out = data_out_q;

    // Next-state for pointers, packet counter and read data
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        if (soft_reset) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            data_out_d = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (rd_acc) begin
                rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, 1'b1};
                data_out_d = rd_word[WIDTH-1:0];
                if (rd_word[WIDTH]) begin
                    count_d = hdr_count;
                end else if (count_q != 7'd0) begin
                    count_d = count_q - 7'd1;
                end
            end else if (count_q == 7'd0) begin
                data_out_d = '0;
            end
        end
    end

    // State registers with synchronous hard reset
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    // Entry write; either reset suppresses it so no partial entry is retained
    always_ff @(posedge clock) begin
        if (!reset && !soft_reset && wr_acc) begin
            mem_q[wr_idx] <= {lfd_state, data_in};
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: queue-based reference model compared every cycle, directed
// scenarios with literal expectations, then a randomized soak.
module tb_router_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             soft_reset = 1'b0;
    logic             write_enb = 1'b0;
    logic             read_enb = 1'b0;
    logic             lfd_state = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [WIDTH:0]   m_q [$];
    int               m_count = 0;
    logic [WIDTH-1:0] m_dout = '0;

    router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .empty      (empty),
        .full       (full)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a FIFO queue plus the packet-count rules, evaluated per edge
    task automatic model_update();
        logic [WIDTH:0] e;
        bit was_full, was_empty, wacc, racc;
        if (reset || soft_reset) begin
            m_q.delete();
            m_count = 0;
            m_dout  = '0;
        end else begin
            was_full  = (m_q.size() == DEPTH);
            was_empty = (m_q.size() == 0);
            wacc = write_enb && !was_full;
            racc = read_enb && !was_empty;
            if (racc) begin
                e = m_q.pop_front();
                m_dout = e[WIDTH-1:0];
                if (e[WIDTH]) m_count = int'(e[WIDTH-1:2]) + 1;
                else if (m_count > 0) m_count = m_count - 1;
            end else if (m_count == 0) begin
                m_dout = '0;
            end
            if (wacc) m_q.push_back({lfd_state, data_in});
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic set_in(input bit we, input bit re, input bit lfd, input logic [WIDTH-1:0] d);
        write_enb = we;
        read_enb  = re;
        lfd_state = lfd;
        data_in   = d;
    endtask

    task automatic do_soft_reset();
        set_in(0, 0, 0, 8'h00);
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
    endtask

    logic [7:0] exp_seq [5];
    logic [6:0] exp_cnt [5];

    initial begin
        fork
            forever begin
                @(negedge clock);
                if (chk_en) begin
                    chk("cyc_data_out", data_out, m_dout);
                    chk("cyc_empty", empty, m_q.size() == 0);
                    chk("cyc_full", full, m_q.size() == DEPTH);
                    chk("cyc_count", dut.count_q, m_count);
                end
            end
        join_none

        // Reset
        step();
        step();
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_data_out", data_out, 8'h00);

        // Fill to full, then a dropped 17th write
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, 0, 0, 8'(i + 1));
            step();
        end
        chk("fill_full", full, 1);
        chk("fill_empty", empty, 0);
        set_in(1, 0, 0, 8'hEE);
        step();
        chk("w17_full", full, 1);
        chk("w17_model_size", m_q.size(), DEPTH);

        // Full with both requests: only the read happens
        set_in(1, 1, 0, 8'h77);
        step();
        chk("fullboth_full", full, 0);
        chk("fullboth_dout", data_out, 8'h01);
        for (int i = 0; i < DEPTH - 1; i++) begin
            set_in(0, 1, 0, 8'h00);
            step();
        end
        chk("drain_empty", empty, 1);
        chk("drain_last", data_out, 8'h10);

        // Empty with both requests: only the write happens
        set_in(0, 0, 0, 8'h00);
        step();
        set_in(1, 1, 0, 8'h55);
        step();
        chk("emptyboth_empty", empty, 0);
        chk("emptyboth_dout", data_out, 8'h00);
        set_in(0, 1, 0, 8'h00);
        step();
        chk("emptyboth_readback", data_out, 8'h55);

        // Packet: header 0D (length 3), three payload bytes, parity
        do_soft_reset();
        set_in(1, 0, 1, 8'h0D); step();
        set_in(1, 0, 0, 8'hA1); step();
        set_in(1, 0, 0, 8'hA2); step();
        set_in(1, 0, 0, 8'hA3); step();
        set_in(1, 0, 0, 8'h5C); step();
        exp_seq = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h5C};
        exp_cnt = '{7'd4, 7'd3, 7'd2, 7'd1, 7'd0};
        for (int i = 0; i < 5; i++) begin
            set_in(0, 1, 0, 8'h00);
            step();
            chk("pkt_dout", data_out, exp_seq[i]);
            chk("pkt_count", dut.count_q, exp_cnt[i]);
        end
        set_in(0, 0, 0, 8'h00);
        step();
        chk("pkt_idle_dout", data_out, 8'h00);

        // Soft reset mid-packet with a concurrent write
        set_in(1, 0, 1, 8'h0D); step();
        set_in(1, 0, 0, 8'hB1); step();
        set_in(1, 0, 0, 8'hB2); step();
        set_in(0, 1, 0, 8'h00); step();
        chk("mid_count", dut.count_q, 7'd4);
        set_in(1, 1, 0, 8'hB3);
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        chk("soft_empty", empty, 1);
        chk("soft_count", dut.count_q, 7'd0);
        chk("soft_dout", data_out, 8'h00);
        set_in(0, 1, 0, 8'h00);
        step();
        chk("soft_nowrite", empty, 1);

        // Wrap crossing: offset pointers, fill across the wrap, interleave
        for (int i = 0; i < 6; i++) begin set_in(1, 0, 0, 8'(8'h20 + i)); step(); end
        for (int i = 0; i < 6; i++) begin set_in(0, 1, 0, 8'h00); step(); end
        chk("wrap_pre_empty", empty, 1);
        for (int i = 0; i < 16; i++) begin set_in(1, 0, 0, 8'(8'h30 + i)); step(); end
        chk("wrap_full", full, 1);
        for (int i = 0; i < 12; i++) begin
            set_in(i >= 1 && i <= 4, 1, 0, 8'(8'h60 + i));
            step();
        end
        chk("wrap_dout12", data_out, 8'h3B);
        while (m_q.size() > 0) begin set_in(0, 1, 0, 8'h00); step(); end
        chk("wrap_end_empty", empty, 1);
        chk("wrap_last", data_out, 8'h64);

        // Randomized soak
        for (int n = 0; n < 3000; n++) begin
            set_in($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                   $urandom_range(0, 7) == 0, 8'($urandom));
            soft_reset = ($urandom_range(0, 99) == 0);
            reset      = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        soft_reset = 1'b0;
        set_in(0, 0, 0, 8'h00);
        step();

        disable fork;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of entries; power of two.
REQ-002 Parameter WIDTH, default 8, payload byte width; stored entry width is WIDTH+1.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous active-high hard reset.
REQ-006 soft_reset  input  1  synchronous flush from the output-port timeout logic, active-high.
REQ-007 write_enb  input  1  write request for this output port, from the synchronizer.
REQ-008 read_enb  input  1  read request from the destination.
REQ-009 lfd_state  input  1  high while the current data_in is a header byte.
REQ-010 data_in  input  WIDTH  byte to store.
REQ-011 data_out  output  WIDTH  registered read data.
REQ-012 empty  output  1  no stored entries.
REQ-013 full  output  1  DEPTH entries stored.

Function
REQ-014 Storage SHALL be DEPTH entries of {lfd_state, data_in}, with bit WIDTH as the header flag.
REQ-015 Write and read pointers SHALL be log2(DEPTH)+1 bits; the index wraps modulo DEPTH and the MSB toggles on each wrap.
REQ-016 empty SHALL equal 1 when the pointers are equal; full SHALL equal 1 when the indices are equal and the MSBs differ; both combinational from the pointers.
REQ-017 Write accepted iff write_enb=1 and full=0; store at wr index, advance wr pointer by 1.
REQ-018 Read accepted iff read_enb=1 and empty=0; data_out <= mem[rd][WIDTH-1:0] on that edge (1-cycle latency); advance rd pointer by 1.
REQ-019 Accept decisions SHALL use full/empty at the start of the cycle; when full with both requests, only the read is accepted; when empty with both requests, only the write is accepted.
REQ-020 Non-accepted requests SHALL be silently dropped, with no pointer, count or data_out change.
REQ-021 Packet counter count, 7 bits: on an accepted read of an entry with header flag 1, count <= data[WIDTH-1:2] + 1 (payload length + parity).
REQ-022 On an accepted read of a non-header entry with count>0, count <= count-1.
REQ-023 On an accepted read of a non-header entry with count=0, count SHALL hold at 0.
REQ-024 In a cycle with no accepted read and count=0, data_out <= 0; with no accepted read and count>0, data_out SHALL hold.
REQ-025 Priority SHALL be reset > soft_reset > normal read/write.
REQ-026 While soft_reset=1, pointers, count and data_out SHALL be cleared and concurrent write_enb/read_enb SHALL be ignored.
REQ-027 Memory contents SHALL need no clearing on soft_reset or reset; they are unreachable once the pointers are equal.

Reset
REQ-028 On reset=1 at a clock edge: pointers=0, count=0, data_out=0, giving empty=1, full=0 on the following cycle.
REQ-029 Reset SHALL abort any in-progress write or read with no partial entry retained.
REQ-030 Outputs SHALL be known (non-X) from the first edge with reset=1.

Verification
REQ-031 Reset, then 16 writes with no reads -> full=1 after the 16th edge; a 17th write is dropped; empty=0.
REQ-032 Write header 8'h0D (length 3, lfd=1) + 3 payload + parity, then read 5 -> data_out sequence 0D,p0,p1,p2,par; count 4,3,2,1,0; next idle cycle data_out=00.
REQ-033 Full FIFO, write_enb=read_enb=1 for one cycle -> one entry read, write dropped, full=0 afterwards.
REQ-034 Empty FIFO, write_enb=read_enb=1 -> write accepted, data_out unchanged, empty=0 next cycle.
REQ-035 Fill 20 writes interleaved with 12 reads crossing the index wrap -> data read back in order; full/empty correct at the wrap boundary.
REQ-036 soft_reset mid-packet with write_enb=1 -> next cycle empty=1, count=0, data_out=00, and the concurrent write not stored.
